data_mem: RTL and testbench

Single-port 256 x 8 data memory for the microprocessor datapath.
- Writes are synchronous to the clock when the write enable is high.
- Reads are combinational from the address at all times.
- An asynchronous active-low reset clears the whole array.
- The block sits between the ALU/register file and the load/store path.

---
 rtl/data_mem_pkg.sv | 11 +
 rtl/data_mem.sv | 30 +++
 tb/tb_data_mem.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/data_mem_pkg.sv
// Shared sizing and word types for the data memory and the CPU datapath around it.
package data_mem_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 2 ** ADDR_W;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] word_t;

endpackage : data_mem_pkg

// File: rtl/data_mem.sv
// 256 x 8 single-port data memory: synchronous write, combinational read,
// asynchronous active-low clear of the whole array.
module data_mem
   import data_mem_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] add,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   input  logic              wr
);

   // Kept as flops rather than block RAM so the whole array can clear asynchronously.
   word_t mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr) begin
         mem[add] <= data_in;
      end
   end

   // Read path has no bypass: a write becomes visible only after its clock edge.
   assign data_out = mem[add];

endmodule : data_mem

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: directed steps plus random traffic against an array model.
module tb_data_mem;

   logic       clk;
   logic       rst_n;
   logic [7:0] add;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       wr;

   logic [7:0] model [256];
   int         vectors;
   int         miscompares;

   data_mem dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .add      (add),
      .data_in  (data_in),
      .data_out (data_out),
      .wr       (wr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [7:0] expected);
      vectors++;
      assert (data_out === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s add=%0d observed=%02h expected=%02h", tag, add, data_out, expected);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < 256; i++) model[i] = 8'h00;
   endtask

   // Read-only probe between edges: no clock involved.
   task automatic read_check(input string tag, input logic [7:0] a);
      wr  = 1'b0;
      add = a;
      #1;
      check_output(tag, model[a]);
   endtask

   // One cycle: drive at negedge, check old word before the edge, new word after it.
   task automatic apply_stimulus(input string tag, input logic w, input logic [7:0] a,
                                 input logic [7:0] d);
      @(negedge clk);
      wr      = w;
      add     = a;
      data_in = d;
      #1;
      check_output({tag, "_pre"}, model[a]);
      @(posedge clk);
      if (w && rst_n) model[a] = d;
      #1;
      check_output({tag, "_post"}, model[a]);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      wr          = 1'b0;
      add         = 8'h00;
      data_in     = 8'h00;
      clear_model();

      // Reset sweep: every address reads zero while held in reset.
      #3;
      for (int i = 0; i < 256; i++) begin
         add = i[7:0];
         #1;
         check_output("reset_sweep", 8'h00);
      end

      @(negedge clk);
      rst_n = 1'b1;
      read_check("after_release", 8'h00);

      for (int i = 0; i < 8; i++) begin
         apply_stimulus("fill", 1'b1, i[7:0], i[7:0] + 8'd8);
      end
      @(negedge clk);
      for (int i = 0; i < 9; i++) begin
         read_check("readback", i[7:0]);
      end
      vectors++;
      assert (model[8] === 8'h00 && model[7] === 8'd15)
      else begin
         miscompares++;
         $error("[TB] FAIL model_sanity observed=%02h expected=%02h", model[7], 8'd15);
      end

      // Write enable low for several cycles leaves mem[3] alone.
      for (int i = 0; i < 4; i++) begin
         apply_stimulus("wr_off", 1'b0, 8'd3, 8'hAA);
      end
      @(negedge clk);
      wr  = 1'b0;
      add = 8'd3;
      #1;
      check_output("wr_off_value", 8'd11);

      apply_stimulus("top_addr", 1'b1, 8'd255, 8'hFF);
      apply_stimulus("low_addr", 1'b1, 8'd0, 8'h5A);
      @(negedge clk);
      read_check("top_readback", 8'd255);
      read_check("low_readback", 8'd0);
      apply_stimulus("overwrite1", 1'b1, 8'd255, 8'h12);
      apply_stimulus("overwrite2", 1'b1, 8'd255, 8'h34);
      @(negedge clk);
      wr  = 1'b0;
      add = 8'd255;
      #1;
      check_output("last_write_wins", 8'h34);

      // Read-during-write on address 4 with explicit constants.
      @(negedge clk);
      wr      = 1'b1;
      add     = 8'd4;
      data_in = 8'h77;
      #1;
      check_output("rdw_before", 8'd12);
      @(posedge clk);
      model[4] = 8'h77;
      #1;
      check_output("rdw_after", 8'h77);

      // Random traffic against the array model.
      for (int n = 0; n < 300; n++) begin
         apply_stimulus("random", 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      end
      @(negedge clk);
      for (int n = 0; n < 64; n++) begin
         read_check("random_read", 8'($urandom));
      end

      // Mid-operation reset: clear is immediate and blocks the write on the edge during reset.
      for (int i = 0; i < 8; i++) begin
         apply_stimulus("refill", 1'b1, i[7:0], 8'hC0 | i[7:0]);
      end
      @(negedge clk);
      wr      = 1'b1;
      add     = 8'd5;
      data_in = 8'h99;
      #2;
      rst_n = 1'b0;
      clear_model();
      #1;
      check_output("reset_immediate", 8'h00);
      add = 8'd2;
      @(posedge clk);
      #1;
      check_output("reset_blocks_write", 8'h00);
      @(negedge clk);
      wr    = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         read_check("post_reset", i[7:0]);
      end
      read_check("post_reset_top", 8'd255);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_data_mem
